// File: rtl/mult_rr_sched.sv
// Round-robin arbiter sharing one unsigned WxW multiplier among NREQ valid/ready requesters.
// Result appears MUL_LAT edges after accept; no new accept until the result handshakes.
module mult_rr_sched #(
   parameter int NREQ    = 4,
   parameter int W       = 4,
   parameter int MUL_LAT = 2,
   parameter int IDW     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [2*W-1:0]    res_data,
   output logic [IDW-1:0]    res_id,
   output logic              busy
);

   localparam int CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic [IDW-1:0]  op_id;

   logic            gnt_vld;
   logic [IDW-1:0]  gnt_idx;
   logic [2*W-1:0]  prod;

   // Scan from the farthest offset down so the nearest valid index at/after ptr wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[(int'(ptr) + k) % NREQ]) begin
            gnt_vld = 1'b1;
            gnt_idx = IDW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst_n && state == IDLE && gnt_vld)
         req_ready = NREQ'(1) << gnt_idx;
   end

   assign prod = (2*W)'(op_a) * (2*W)'(op_b);
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_id     <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_vld) begin
                  op_a  <= req_a[gnt_idx*W +: W];
                  op_b  <= req_b[gnt_idx*W +: W];
                  op_id <= gnt_idx;
                  ptr   <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
                  cnt   <= CW'(MUL_LAT);
                  state <= CALC;
               end
            end
            CALC: begin
               if (cnt == CW'(1)) begin
                  res_data  <= prod;
                  res_id    <= op_id;
                  res_valid <= 1'b1;
                  state     <= RESP;
               end
               cnt <= cnt - 1'b1;
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_rr_sched.sv
// Random-stimulus bench for mult_rr_sched against a timestamp-based reference model.
module tb_mult_rr_sched;

   localparam int NREQ    = 4;
   localparam int W       = 4;
   localparam int MUL_LAT = 2;
   localparam int IDW     = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic              res_valid;
   logic              res_ready;
   logic [2*W-1:0]    res_data;
   logic [IDW-1:0]    res_id;
   logic              busy;

   mult_rr_sched #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0d got=%0h want=%0h", tag, t, obs, exp);
      end
   endtask

   // Reference model state: one job in flight, visible from m_ready_at onwards.
   int          m_ptr;
   bit          m_busy;
   int          m_ready_at;
   int          m_data;
   int          m_id;
   int          a_val [NREQ];
   int          b_val [NREQ];
   int          grant_log [$];

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++)
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic check_reset_outputs();
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_data",  32'(res_data), 0);
      chk("rst_res_id",    32'(res_id), 0);
      chk("rst_busy",      32'(busy), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
   endtask

   initial begin
      int  g;
      int  rst_hold;
      bit  exp_rv;
      int  mode;

      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
      m_ptr = 0; m_busy = 0; m_ready_at = 0; m_data = 0; m_id = 0; rst_hold = 0;
      t = 0;
      #2;
      check_reset_outputs();

      for (t = 0; t < 3000; t++) begin
         @(negedge clk);
         // Phase 0: everyone valid with a_i=i+1,b=2 and a ready consumer.
         mode = (t < 60) ? 0 : ((t < 2200) ? 1 : 2);
         for (int i = 0; i < NREQ; i++) begin
            if (mode == 0) begin
               a_val[i] = i + 1; b_val[i] = 2;
            end else if (mode == 2) begin
               a_val[i] = ($urandom_range(0, 1) == 1) ? 15 : 0;
               b_val[i] = ($urandom_range(0, 1) == 1) ? 15 : 9;
            end else begin
               a_val[i] = $urandom_range(0, 15);
               b_val[i] = $urandom_range(0, 15);
            end
            req_a[i*W +: W] = W'(a_val[i]);
            req_b[i*W +: W] = W'(b_val[i]);
         end
         req_valid = (mode == 0) ? '1 : NREQ'($urandom_range(0, (1 << NREQ) - 1));
         res_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 6);

         if (t < 3) rst_hold = 1;
         else if (rst_hold == 0 && m_busy && t > 60 && $urandom_range(0, 49) == 0)
            rst_hold = $urandom_range(1, 3);

         if (rst_hold > 0) begin
            rst_n = 1'b0;
            rst_hold--;
            m_ptr = 0; m_busy = 0;
            #1;
            check_reset_outputs();
            continue;
         end
         rst_n = 1'b1;
         #1;

         g = m_busy ? -1 : pick(req_valid, m_ptr);
         exp_rv = m_busy && (t >= m_ready_at);
         chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
         chk("busy", 32'(busy), 32'(m_busy));
         chk("res_valid", 32'(res_valid), 32'(exp_rv));
         if (exp_rv) begin
            chk("res_data", 32'(res_data), 32'(m_data));
            chk("res_id", 32'(res_id), 32'(m_id));
         end

         // Advance the model across the coming edge.
         if (g >= 0) begin
            m_busy     = 1;
            m_ready_at = t + 1 + MUL_LAT;
            m_data     = a_val[g] * b_val[g];
            m_id       = g;
            m_ptr      = (g + 1) % NREQ;
            if (mode == 0) grant_log.push_back(g);
         end else if (exp_rv && res_ready) begin
            m_busy = 0;
         end
      end

      // Continuous all-valid traffic must rotate strictly 0,1,2,3,0,...
      for (int i = 0; i < 5 && i < grant_log.size(); i++)
         chk("rr_order", 32'(grant_log[i]), 32'(i % NREQ));
      chk("rr_grants_seen", 32'(grant_log.size() >= 5), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
